// File: rtl/uart_pkg.sv
// Shared constants for the UART transmitter: FSM state codes,
// parity-mode codes, per-frame config bundle and parity helper.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    localparam logic [1:0] PAR_SPACE = 2'b00;
    localparam logic [1:0] PAR_MARK  = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_ODD   = 2'b11;

    typedef struct packed {
        logic par_en;
        logic stop2;
    } frame_cfg_t;

    function automatic logic parity_bit(
        input logic [1:0] mode,
        input logic       data_xor
    );
        logic p;
        p = 1'b0;
        unique case (mode)
            PAR_EVEN:  p = data_xor;
            PAR_ODD:   p = ~data_xor;
            PAR_MARK:  p = 1'b1;
            PAR_SPACE: p = 1'b0;
            default:   p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Valid/ready character stream into the UART transmit FIFO.
// Signals: s_data (character), s_valid (producer), s_ready (not-full).
interface uart_tx_fifo_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO, power-of-two depth, occupancy counter.
// Ports: push/wdata/full in, pop/rdata/empty out, level = occupancy.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with transmit FIFO, parity, 1/2 stop bits and break.
// Ports: clk, rst_n, s (char stream), line config inputs, tx, level, busy.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    uart_tx_fifo_if.slave                 s,
    output logic                          tx,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic                          tx_en,
    input  logic                          parity_en,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop_bits,
    input  logic                          break_req,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy
);
    localparam int IW = $clog2(DATA_W);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

    logic [2:0]        state;
    logic [DIV_W-1:0]  baud_cnt;
    logic [DIV_W-1:0]  div_q;
    logic [DATA_W-1:0] shreg;
    logic [IW-1:0]     bit_idx;
    frame_cfg_t        cfg_q;
    logic              par_q;
    logic              stop_last;
    logic              tx_q;
    logic              tx_next;
    logic              tick;
    logic              can_start;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;

    uart_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (s.s_valid),
        .wdata (s.s_data),
        .full  (fifo_full),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .level (level)
    );

    assign s.s_ready = ~fifo_full;
    assign busy      = (state != ST_IDLE);
    assign tx        = tx_q;
    assign tick      = (baud_cnt == '0);
    assign can_start = ~fifo_empty & tx_en & ~break_req;

    // A frame starts from IDLE or straight out of the final stop bit.
    assign pop = can_start &
                 ((state == ST_IDLE) |
                  ((state == ST_STOP) & tick & stop_last));

    // Line level follows the state held during the previous cycle.
    always_comb begin
        tx_next = 1'b1;
        unique case (state)
            ST_START:  tx_next = 1'b0;
            ST_BREAK:  tx_next = 1'b0;
            ST_DATA:   tx_next = shreg[0];
            ST_PARITY: tx_next = par_q;
            default:   tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            div_q     <= '0;
            shreg     <= '0;
            bit_idx   <= '0;
            cfg_q     <= '0;
            par_q     <= 1'b0;
            stop_last <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            tx_q <= tx_next;

            if (state != ST_IDLE && state != ST_BREAK)
                baud_cnt <= tick ? div_q : baud_cnt - 1'b1;

            unique case (state)
                ST_IDLE: begin
                    if (break_req) begin
                        state <= ST_BREAK;
                        div_q <= baud_div;
                    end
                end
                ST_BREAK: begin
                    if (!break_req) begin
                        state     <= ST_STOP;
                        stop_last <= 1'b1;
                        baud_cnt  <= div_q;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state   <= ST_DATA;
                        bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shreg <= shreg >> 1;
                        if (bit_idx == LAST_BIT) begin
                            state <= cfg_q.par_en ? ST_PARITY : ST_STOP;
                            stop_last <= ~cfg_q.stop2;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        state     <= ST_STOP;
                        stop_last <= ~cfg_q.stop2;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (!stop_last) begin
                            stop_last <= 1'b1;
                        end else begin
                            state    <= ST_IDLE;
                            baud_cnt <= '0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Frame load overrides the STOP->IDLE exit for back-to-back.
            if (pop) begin
                state    <= ST_START;
                shreg    <= fifo_rdata;
                par_q    <= parity_bit(parity_mode, ^fifo_rdata);
                cfg_q    <= '{par_en: parity_en, stop2: stop_bits};
                div_q    <= baud_div;
                baud_cnt <= baud_div;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed and random frames
// compared sample-by-sample against a bit-list frame model.
module tb_uart_tx_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int DIVW  = 16;

    typedef logic bitq_t[$];

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    tx;
    logic [DIVW-1:0]         baud_div;
    logic                    tx_en;
    logic                    parity_en;
    logic [1:0]              parity_mode;
    logic                    stop_bits;
    logic                    break_req;
    logic [$clog2(DEPTH):0]  level;
    logic                    busy;

    int checks = 0;
    int errors = 0;

    int         cur_div;
    logic       cur_pen;
    logic [1:0] cur_pm;
    logic       cur_st2;

    uart_tx_fifo_if #(.DATA_W(DW)) sif ();

    uart_tx_fifo #(
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH),
        .DIV_W      (DIVW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s           (sif),
        .tx          (tx),
        .baud_div    (baud_div),
        .tx_en       (tx_en),
        .parity_en   (parity_en),
        .parity_mode (parity_mode),
        .stop_bits   (stop_bits),
        .break_req   (break_req),
        .level       (level),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line bits of one frame, in transmission order.
    function automatic bitq_t frame_model(input logic [DW-1:0] d,
                                          input logic pen,
                                          input logic [1:0] pm,
                                          input logic st2);
        bitq_t q;
        int ones;
        ones = $countones(d);
        q.push_back(1'b0);
        for (int i = 0; i < DW; i++) q.push_back(d[i]);
        if (pen) begin
            case (pm)
                2'b10:   q.push_back(1'(ones % 2));
                2'b11:   q.push_back(1'((ones + 1) % 2));
                2'b01:   q.push_back(1'b1);
                default: q.push_back(1'b0);
            endcase
        end
        q.push_back(1'b1);
        if (st2) q.push_back(1'b1);
        return q;
    endfunction

    task automatic set_cfg(input int div, input logic pen,
                           input logic [1:0] pm, input logic st2);
        cur_div     = div;
        cur_pen     = pen;
        cur_pm      = pm;
        cur_st2     = st2;
        baud_div    = DIVW'(div);
        parity_en   = pen;
        parity_mode = pm;
        stop_bits   = st2;
    endtask

    // Drive one word for exactly one rising edge.
    task automatic push(input logic [DW-1:0] d, output logic acc);
        sif.s_data  = d;
        sif.s_valid = 1'b1;
        acc = sif.s_ready;
        @(posedge clk);
        #1;
        sif.s_valid = 1'b0;
        sif.s_data  = DW'($urandom);
    endtask

    task automatic check_frame(input logic [DW-1:0] d, input string tag,
                               input int brk_bit, input bit scramble,
                               output int gap);
        bitq_t q;
        int div;
        div = cur_div;
        q = frame_model(d, cur_pen, cur_pm, cur_st2);
        gap = 0;
        while (tx !== 1'b0 && gap < 400) begin
            @(negedge clk);
            gap++;
        end
        chk({tag, "_start"}, 32'(tx), 32'(0));
        if (tx !== 1'b0) return;
        if (scramble) begin
            baud_div    = DIVW'($urandom_range(0, 40));
            parity_en   = 1'($urandom);
            parity_mode = 2'($urandom);
            stop_bits   = 1'($urandom);
            tx_en       = 1'($urandom);
        end
        foreach (q[b]) begin
            if (b == brk_bit) break_req = 1'b1;
            for (int c = 0; c <= div; c++) begin
                chk($sformatf("%s_bit%0d", tag, b), 32'(tx), 32'(q[b]));
                @(negedge clk);
            end
        end
    endtask

    initial begin
        logic          acc;
        logic          exp_acc;
        int            gap;
        int            n;
        logic [DW-1:0] d;
        logic [DW-1:0] d2;
        logic [DW-1:0] mq[$];

        rst_n       = 1'b0;
        tx_en       = 1'b0;
        break_req   = 1'b0;
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        set_cfg(0, 1'b0, 2'b00, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_level", 32'(level), 32'(0));
        chk("rst_ready", 32'(sif.s_ready), 32'(1));
        rst_n = 1'b1;

        // 0x55, div 3, 8N1, latency from push edge
        set_cfg(3, 1'b0, 2'b00, 1'b0);
        tx_en = 1'b1;
        push(8'h55, acc);
        chk("lat_acc", 32'(acc), 32'(1));
        @(negedge clk);
        chk("lat_k", 32'(tx), 32'(1));
        @(negedge clk);
        chk("lat_k1", 32'(tx), 32'(1));
        chk("busy_frame", 32'(busy), 32'(1));
        @(negedge clk);
        chk("lat_k2", 32'(tx), 32'(0));
        check_frame(8'h55, "f55", -1, 1'b0, gap);
        chk("f55_busy_end", 32'(busy), 32'(0));
        chk("f55_level", 32'(level), 32'(0));

        // parity modes on 0x07
        for (int m = 0; m < 4; m++) begin
            set_cfg(1, 1'b1, 2'(m), 1'b0);
            push(8'h07, acc);
            check_frame(8'h07, $sformatf("par%0d", m), -1, 1'b0, gap);
        end

        // two stop bits at div 9, back-to-back pair
        set_cfg(9, 1'b0, 2'b00, 1'b1);
        push(8'hC3, acc);
        push(8'h3A, acc);
        check_frame(8'hC3, "st2a", -1, 1'b0, gap);
        check_frame(8'h3A, "st2b", -1, 1'b0, gap);
        chk("st2_gap", 32'(gap), 32'(0));

        // fill with tx_en low, overflow, then drain back-to-back
        tx_en = 1'b0;
        set_cfg(2, 1'b1, 2'b11, 1'b0);
        for (int i = 0; i < 5; i++) begin
            d = DW'($urandom);
            push(d, acc);
            exp_acc = (mq.size() < DEPTH);
            chk("fill_acc", 32'(acc), 32'(exp_acc));
            if (exp_acc) mq.push_back(d);
        end
        chk("fill_ready", 32'(sif.s_ready), 32'(0));
        chk("fill_level", 32'(level), 32'(mq.size()));
        tx_en = 1'b1;
        push(8'hEE, acc);
        chk("full_pushpop_acc", 32'(acc), 32'(mq.size() < DEPTH));
        chk("full_pushpop_lvl", 32'(level), 32'(mq.size() - 1));
        for (int i = 0; i < mq.size(); i++) begin
            check_frame(mq[i], $sformatf("drain%0d", i), -1, 1'b0, gap);
            if (i > 0) chk("drain_gap", 32'(gap), 32'(0));
        end
        chk("drain_level", 32'(level), 32'(0));
        mq.delete();

        // random single frames with inputs scrambled mid-frame
        for (int it = 0; it < 8; it++) begin
            tx_en = 1'b1;
            set_cfg((it == 0) ? 0 : $urandom_range(0, 4), 1'($urandom),
                    2'($urandom), 1'($urandom));
            d = DW'($urandom);
            push(d, acc);
            check_frame(d, $sformatf("rnd%0d", it), -1, 1'b1, gap);
        end

        // random back-to-back pairs
        tx_en = 1'b1;
        for (int it = 0; it < 3; it++) begin
            set_cfg($urandom_range(0, 3), 1'($urandom), 2'($urandom),
                    1'($urandom));
            d  = DW'($urandom);
            d2 = DW'($urandom);
            push(d, acc);
            push(d2, acc);
            check_frame(d, $sformatf("pa%0d", it), -1, 1'b0, gap);
            check_frame(d2, $sformatf("pb%0d", it), -1, 1'b0, gap);
            chk("pair_gap", 32'(gap), 32'(0));
        end

        // break raised mid-DATA, data queued during break
        set_cfg(2, 1'b0, 2'b00, 1'b0);
        push(8'hA3, acc);
        check_frame(8'hA3, "brkf", 3, 1'b0, gap);
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("brk_low", 32'(tx), 32'(0));
        push(8'h3C, acc);
        chk("brk_push", 32'(acc), 32'(1));
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (tx !== 1'b0) n++;
        end
        chk("brk_hold", 32'(n), 32'(0));
        chk("brk_level", 32'(level), 32'(1));
        chk("brk_busy", 32'(busy), 32'(1));
        break_req = 1'b0;
        n = 0;
        while (tx !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("brk_release", 32'(tx), 32'(1));
        check_frame(8'h3C, "postbrk", -1, 1'b0, gap);
        chk("brk_stop_gap", 32'(gap >= cur_div + 1), 32'(1));

        // reset pulsed mid-DATA with words queued
        set_cfg(3, 1'b0, 2'b00, 1'b0);
        tx_en = 1'b0;
        for (int i = 0; i < 4; i++) push(DW'($urandom), acc);
        tx_en = 1'b1;
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rstmid_start", 32'(tx), 32'(0));
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_tx", 32'(tx), 32'(1));
        chk("rstmid_level", 32'(level), 32'(0));
        chk("rstmid_ready", 32'(sif.s_ready), 32'(1));
        chk("rstmid_busy", 32'(busy), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) n++;
        end
        chk("rstmid_quiet", 32'(n), 32'(0));
        chk("rstmid_level2", 32'(level), 32'(0));
        chk("rstmid_busy2", 32'(busy), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_W, default 8, meaning character length in bits; legal range 5..9.
REQ-002 Parameter FIFO_DEPTH, default 16, meaning transmit FIFO entries; must be a power of two, 2..256.
REQ-003 Parameter DIV_W, default 16, meaning width of the baud divisor.
REQ-004 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port tx  output  1  serial line; idle level 1.
REQ-007 Port baud_div  input  DIV_W  bit period minus one, in clk cycles.
REQ-008 Port tx_en  input  1  when 0, no new frame starts; a frame in progress completes.
REQ-009 Port parity_en  input  1  1 inserts a parity bit.
REQ-010 Port parity_mode  input  2  11 odd, 10 even, 01 mark (1), 00 space (0).
REQ-011 Port stop_bits  input  1  0 selects one stop bit; 1 selects two stop bits.
REQ-012 Port break_req  input  1  request to hold the line low (break).
REQ-013 Port s_data  input  DATA_W  character to enqueue.
REQ-014 Port s_valid  input  1  s_data is valid.
REQ-015 Port s_ready  output  1  FIFO can accept; equals not-full.
REQ-016 Port level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-017 Port busy  output  1  high in any state other than IDLE.

Function
REQ-018 A word is enqueued on a rising edge where s_valid and s_ready are both 1; s_data is ignored otherwise.
REQ-019 On a simultaneous push and pop at full, s_ready stays 0; at empty, the push is not visible for pop until the next cycle.
REQ-020 The FSM has states IDLE, START, DATA, PARITY, STOP, and BREAK.
REQ-021 IDLE->START occurs when the FIFO is non-empty, tx_en is 1, and break_req is 0; the head word is popped and loaded into the shift register on the same edge.
REQ-022 On the IDLE->START edge, baud_div, parity_en, parity_mode, and stop_bits are latched; they are held for the whole frame.
REQ-023 tx is a registered output: 0 in START, shift register bit 0 in DATA (LSB first), the parity bit in PARITY, 1 in STOP and IDLE, and 0 in BREAK.
REQ-024 Every bit lasts exactly latched baud_div+1 clk cycles, timed by a down-counter reloaded at each bit boundary.
REQ-025 A baud_div value of 0 gives a bit period of one cycle.
REQ-026 DATA lasts DATA_W bit periods, then moves to PARITY if parity_en is 1, else to STOP.
REQ-027 STOP lasts 1 or 2 bit periods, then returns to IDLE.
REQ-028 For back-to-back frames, STOP goes directly to START with no idle gap when the IDLE->START conditions hold.
REQ-029 The parity bit is the XOR of all DATA_W data bits (even), its inverse (odd), 1 (mark), or 0 (space).
REQ-030 IDLE->BREAK occurs when break_req is 1; break_req has priority over pending FIFO data.
REQ-031 BREAK holds tx at 0 while break_req is 1, then enters STOP for one bit period.
REQ-032 A break_req raised mid-frame waits until the frame ends.
REQ-033 Latency: a word accepted at edge k into an empty FIFO, with the FSM in IDLE and tx_en at 1, drives tx to 0 from edge k+2.
REQ-034 level increments on push, decrements on pop, and is unchanged on simultaneous push and pop; FIFO pointers wrap modulo FIFO_DEPTH.

Reset
REQ-035 While rst_n is 0: tx=1, busy=0, level=0, s_ready=1, state=IDLE, FIFO pointers=0, and the baud counter is 0.
REQ-036 Reset asserted mid-frame aborts the frame immediately and discards all FIFO contents.
REQ-037 The first frame after reset deassertion may start no earlier than the second rising edge.

Structure
REQ-038 The state encoding and parity-mode constants shall reside in shared package uart_pkg.
REQ-039 The FIFO shall be a separate sub-module uart_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level).
REQ-040 The FSM, baud counter, and shift register shall reside in uart_tx_fifo.

Verification
REQ-041 DATA_W=8, baud_div=3, no parity, 1 stop, push 0x55 -> tx is 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles, 40 cycles total, busy drops after.
REQ-042 Even parity, push 0x07 -> parity bit 1; odd parity, push 0x07 -> parity bit 0; mark mode -> 1; space mode -> 0.
REQ-043 FIFO_DEPTH=4, tx_en=0, push 5 words -> 4 accepted, s_ready=0, level=4; set tx_en=1 -> 4 frames sent back-to-back with no idle gap.
REQ-044 stop_bits=1, baud_div=9 -> stop phase is 20 cycles high before the next start bit.
REQ-045 break_req raised during DATA -> frame completes, tx=0 while break_req is 1, then at least 1 bit period high before the next START.
REQ-046 rst_n pulsed low mid-DATA with 3 words queued -> tx=1 immediately, level=0, and no further frame is sent.
